// File: rtl/mlp_seq_pkg.sv
// Shared types and helpers for the printed-MLP input sequencer.
// Optional macro MLP_SEQ_TRIPLE_SAMPLE_EN enables triple sampling with majority vote in the top.
package mlp_seq_pkg;

  localparam int NUM_A_DEF         = 4;
  localparam int WIDTH_A_DEF       = 4;
  localparam int OUTWIDTH_DEF      = 2;
  localparam int SETTLE_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    RESULT  = 2'd3
  } seq_state_e;

  // Single-bit majority; vectors apply it bit by bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mlp_seq_settle_timer.sv
// Settle-window down-counter: load SETTLE_CYCLES-1, decrement while enabled, done at zero.
module mlp_seq_settle_timer #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int              CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] count_q;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/mlp_input_sequencer.sv
// Serial feature loader, settle timer and result handshake around the combinational MLP `top`.
// Define MLP_SEQ_TRIPLE_SAMPLE_EN for a 3-cycle capture with bitwise majority and instability flag.
module mlp_input_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int NUM_A         = NUM_A_DEF,
  parameter int WIDTH_A       = WIDTH_A_DEF,
  parameter int OUTWIDTH      = OUTWIDTH_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       feat_valid,
  output logic                       feat_ready,
  input  logic [WIDTH_A-1:0]         feat_data,
  input  logic                       feat_last,
  output logic [NUM_A*WIDTH_A-1:0]   inp,
  input  logic [OUTWIDTH-1:0]        mlp_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUTWIDTH-1:0]        res_class,
  output logic                       res_error,
  output logic                       busy
);

  localparam int                IDX_W    = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_A - 1);

  seq_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q;
  logic [NUM_A*WIDTH_A-1:0]    inp_q, inp_d;
  logic                        err_q;
  logic                        accept, sample_end, framing_err;
  logic                        timer_load, timer_done;
  logic                        cap_done, cap_unstable;
  logic [OUTWIDTH-1:0]         cap_cls;

  assign sample_end  = feat_last || (idx_q == LAST_IDX);
  assign framing_err = sample_end && !((idx_q == LAST_IDX) && feat_last);

  mlp_seq_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .en    (state_q == SETTLE),
    .done  (timer_done)
  );

`ifdef MLP_SEQ_TRIPLE_SAMPLE_EN
  logic [1:0]          cap_cnt_q;
  logic [OUTWIDTH-1:0] s0_q, s1_q;

  // The third sample is taken straight from mlp_out on the final capture edge.
  always_comb begin
    cap_cls = '0;
    for (int b = 0; b < OUTWIDTH; b++) begin
      cap_cls[b] = maj3(s0_q[b], s1_q[b], mlp_out[b]);
    end
    cap_unstable = (s0_q != s1_q) || (s1_q != mlp_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cnt_q <= '0;
      s0_q      <= '0;
      s1_q      <= '0;
    end else if (state_q == CAPTURE) begin
      cap_cnt_q <= cap_done ? 2'd0 : cap_cnt_q + 2'd1;
      if (cap_cnt_q == 2'd0) s0_q <= mlp_out;
      if (cap_cnt_q == 2'd1) s1_q <= mlp_out;
    end
  end
`else
  assign cap_cls      = mlp_out;
  assign cap_unstable = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    timer_load = 1'b0;
    cap_done   = 1'b0;
    inp_d      = inp_q;
    for (int i = 0; i < NUM_A; i++) begin
      if (IDX_W'(i) == idx_q) begin
        inp_d[i*WIDTH_A +: WIDTH_A] = feat_data;
      end else if (feat_last && (IDX_W'(i) > idx_q)) begin
        inp_d[i*WIDTH_A +: WIDTH_A] = '0;
      end
    end
    case (state_q)
      LOAD: begin
        if (feat_valid && feat_ready) begin
          accept = 1'b1;
          if (sample_end) begin
            state_d    = SETTLE;
            timer_load = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (timer_done) state_d = CAPTURE;
      end
      CAPTURE: begin
`ifdef MLP_SEQ_TRIPLE_SAMPLE_EN
        if (cap_cnt_q == 2'd2) begin
          cap_done = 1'b1;
          state_d  = RESULT;
        end
`else
        cap_done = 1'b1;
        state_d  = RESULT;
`endif
      end
      RESULT: begin
        if (res_valid && res_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // feat_ready is registered so it rises one cycle after reset deassert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_ready <= 1'b0;
      inp_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      res_valid  <= 1'b0;
      res_class  <= '0;
      res_error  <= 1'b0;
    end else begin
      feat_ready <= (state_d == LOAD);
      if (accept) begin
        inp_q <= inp_d;
        err_q <= ((idx_q != '0) && err_q) || framing_err;
        if (!sample_end) idx_q <= idx_q + 1'b1;
      end
      if (cap_done) begin
        res_class <= cap_cls;
        res_error <= err_q || cap_unstable;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
        idx_q     <= '0;
      end
    end
  end

  assign inp  = inp_q;
  assign busy = !((state_q == LOAD) && (idx_q == '0));

endmodule

// File: tb/tb_mlp_input_sequencer.sv
// Randomized self-checking bench for mlp_input_sequencer against a sample-level reference model.
// Build with MLP_SEQ_TRIPLE_SAMPLE_EN to also exercise triple-sample capture.
module tb_mlp_input_sequencer;

  localparam int S = 8;
`ifdef MLP_SEQ_TRIPLE_SAMPLE_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = S + 1 + EXTRA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        feat_valid = 1'b0;
  logic        feat_ready;
  logic [3:0]  feat_data = '0;
  logic        feat_last = 1'b0;
  logic [15:0] inp;
  logic [1:0]  mlp_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [1:0]  res_class;
  logic        res_error;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic       mlp_mode = 1'b0;
  logic [1:0] force_cls = '0;

  always #5 clk = ~clk;

  // Stand-in for the printed MLP: class = sum of features mod 4.
  function automatic logic [1:0] ref_top(input logic [15:0] x);
    int s;
    s = int'(x[3:0]) + int'(x[7:4]) + int'(x[11:8]) + int'(x[15:12]);
    return 2'(s);
  endfunction

  assign mlp_out = mlp_mode ? force_cls : ref_top(inp);

  mlp_input_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feat_data  (feat_data),
    .feat_last  (feat_last),
    .inp        (inp),
    .mlp_out    (mlp_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_class  (res_class),
    .res_error  (res_error),
    .busy       (busy)
  );

  // Sample ends at the first beat marked last, or at the 4th beat; missing slots read 0.
  task automatic model_sample(input logic [3:0] d[4], input logic l[4],
                              output int used, output logic [15:0] e_inp, output logic e_err);
    used = 3;
    for (int k = 3; k >= 0; k--) if (l[k]) used = k;
    e_inp = '0;
    for (int k = 0; k <= used; k++) e_inp[k*4 +: 4] = d[k];
    e_err = !((used == 3) && l[3]);
  endtask

  task automatic send_beat(input logic [3:0] d, input logic l);
    int   waited = 0;
    logic took = 1'b0;
    feat_valid = 1'b1;
    feat_data  = d;
    feat_last  = l;
    while (!took && waited < 50) begin
      took = feat_ready;
      @(posedge clk); #1;
      waited++;
    end
    feat_valid = 1'b0;
    feat_last  = 1'b0;
    vectors++;
    if (!took) begin
      miscompares++;
      $display("FAIL beat_accept: beat %0h not accepted within %0d cycles", d, waited);
    end
  endtask

  task automatic run_sample(input logic [3:0] d[4], input logic l[4], input int hold,
                            input logic early, input string tag);
    int          used, lat;
    logic [15:0] e_inp;
    logic        e_err, bad_inp, bad_hold;
    logic [1:0]  e_cls;
    model_sample(d, l, used, e_inp, e_err);
    e_cls = mlp_mode ? force_cls : ref_top(e_inp);
    for (int k = 0; k <= used; k++) send_beat(d[k], l[k]);
    vectors++;
    if (inp !== e_inp || busy !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s load: inp=%h busy=%b res_valid=%b, want inp=%h busy=1 res_valid=0",
               tag, inp, busy, res_valid, e_inp);
    end
    if (early) res_ready = 1'b1;
    lat = 0;
    bad_inp = 1'b0;
    while (res_valid !== 1'b1 && lat < 100) begin
      if (inp !== e_inp) bad_inp = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat != LAT || bad_inp) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges (inp glitch=%b), want %0d", tag, lat, bad_inp, LAT);
    end
    vectors++;
    if (res_class !== e_cls || res_error !== e_err) begin
      miscompares++;
      $display("FAIL %s result: class=%0d err=%b, want class=%0d err=%b",
               tag, res_class, res_error, e_cls, e_err);
    end
    bad_hold = 1'b0;
    for (int h = 0; h < hold; h++) begin
      feat_valid = 1'b1;
      feat_data  = 4'($urandom);
      @(posedge clk); #1;
      if (feat_ready !== 1'b0 || res_valid !== 1'b1 || res_class !== e_cls || inp !== e_inp)
        bad_hold = 1'b1;
    end
    feat_valid = 1'b0;
    if (hold > 0) begin
      vectors++;
      if (bad_hold) begin
        miscompares++;
        $display("FAIL %s hold: state moved while res_ready low (feat_ready=%b class=%0d inp=%h)",
                 tag, feat_ready, res_class, inp);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || feat_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s handshake: res_valid=%b feat_ready=%b busy=%b, want 0 1 0",
               tag, res_valid, feat_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (inp !== 16'h0 || res_valid !== 1'b0 || res_class !== 2'd0 || res_error !== 1'b0 ||
        feat_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: inp=%h rv=%b cls=%0d err=%b fr=%b busy=%b, want all 0",
               inp, res_valid, res_class, res_error, feat_ready, busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (feat_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: feat_ready=%b one cycle after release, want 1", feat_ready);
    end
  endtask

  task automatic test_basic();
    logic [3:0] d[4] = '{4'd1, 4'd5, 4'd3, 4'd2};
    logic       l[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    mlp_mode  = 1'b1;
    force_cls = 2'd1;
    run_sample(d, l, 0, 1'b0, "basic");
    mlp_mode  = 1'b0;
  endtask

  task automatic test_short_sample();
    logic [3:0] d[4] = '{4'd7, 4'd9, 4'd0, 4'd0};
    logic       l[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] c[4] = '{4'd15, 4'd0, 4'd8, 4'd6};
    logic       cl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_sample(d, l, 0, 1'b0, "short");
    run_sample(c, cl, 0, 1'b0, "after_short");
  endtask

  task automatic test_missing_last();
    logic [3:0] d[4] = '{4'd3, 4'd12, 4'd10, 4'd1};
    logic [3:0] e[4] = '{4'd4, 4'd4, 4'd14, 4'd9};
    logic       l[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_sample(d, l, 0, 1'b0, "no_last_a");
    run_sample(e, l, 0, 1'b0, "no_last_b");
  endtask

  task automatic test_result_hold();
    logic [3:0] d[4] = '{4'd2, 4'd11, 4'd13, 4'd5};
    logic       l[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_sample(d, l, 20, 1'b0, "hold");
  endtask

  task automatic test_early_ready();
    logic [3:0] d[4] = '{4'd9, 4'd6, 4'd1, 4'd0};
    logic       l[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    run_sample(d, l, 0, 1'b1, "early_ready");
  endtask

  task automatic test_reset_in_settle();
    logic [3:0] d[4] = '{4'd5, 4'd7, 4'd2, 4'd3};
    logic       l[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) send_beat(d[k], l[k]);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (inp !== 16'h0 || res_valid !== 1'b0 || busy !== 1'b0 || feat_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_settle: inp=%h rv=%b busy=%b fr=%b, want 0 0 0 0",
               inp, res_valid, busy, feat_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    d = '{4'd8, 4'd1, 4'd4, 4'd12};
    run_sample(d, l, 0, 1'b0, "post_reset");
  endtask

`ifdef MLP_SEQ_TRIPLE_SAMPLE_EN
  task automatic test_triple_sample();
    logic [3:0] d[4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic       l[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) send_beat(d[k], l[k]);
    repeat (S) @(posedge clk);
    #1;
    mlp_mode  = 1'b1;
    force_cls = 2'd2;
    @(posedge clk); #1;
    force_cls = 2'd3;
    @(posedge clk); #1;
    force_cls = 2'd2;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL triple_early: res_valid=%b before third capture, want 0", res_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (res_valid !== 1'b1 || res_class !== 2'd2 || res_error !== 1'b1) begin
      miscompares++;
      $display("FAIL triple_result: rv=%b class=%0d err=%b, want 1 2 1",
               res_valid, res_class, res_error);
    end
    mlp_mode  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [3:0] d[4];
    logic       l[4];
    int         n, hold;
    for (int t = 0; t < 24; t++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) begin
        d[k] = 4'($urandom_range(0, 15));
        l[k] = 1'b0;
      end
      if (n < 4 || $urandom_range(0, 1) == 1) l[n-1] = 1'b1;
      hold = $urandom_range(0, 3);
      run_sample(d, l, hold, (hold == 0) && ($urandom_range(0, 1) == 1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_sample();
    test_missing_last();
    test_result_hold();
    test_early_ready();
    test_reset_in_settle();
`ifdef MLP_SEQ_TRIPLE_SAMPLE_EN
    test_triple_sample();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mlp_input_sequencer.md
Name: mlp_input_sequencer

Overview:
Clocked front/back-end for the combinational printed-MLP `top` (4 features x 4 bit in, 2-bit class out).
- Accepts features serially over a valid/ready stream and assembles them into the packed `inp` vector.
- Holds `inp` stable for a programmable settle window, long enough for the slow printed combinational logic.
- Samples the class output and returns it on a result valid/ready handshake.
- Sits between the sample source (bench or on-chip feature buffer) and `top`.

Parameters:
- NUM_A, 4, features per sample
- WIDTH_A, 4, bits per feature (unsigned)
- OUTWIDTH, 2, class index width from `top`
- SETTLE_CYCLES, 8, clk cycles `inp` is held before sampling; legal range >=1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- feat_valid  in  1  feature beat valid
- feat_ready  out  1  sequencer accepts beat
- feat_data  in  WIDTH_A  feature value
- feat_last  in  1  marks final feature of sample
- inp  out  NUM_A*WIDTH_A  packed features to `top`; feature i at [(i+1)*WIDTH_A-1 : i*WIDTH_A]
- mlp_out  in  OUTWIDTH  class output of `top`
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_class  out  OUTWIDTH  captured class
- res_error  out  1  framing error on this sample
- busy  out  1  high in any state except LOAD with index 0

Behaviour:
- Reset (async assert, sync deassert by user):
  - state=LOAD, feature index=0, inp=0, res_valid=0, res_class=0, res_error=0, settle counter=0.
  - feat_ready goes high one cycle after reset deassert.
- States: LOAD -> SETTLE -> CAPTURE -> RESULT -> LOAD.
- LOAD:
  - feat_ready=1. A beat transfers on feat_valid&feat_ready.
  - The beat writes feature slot[idx], then idx increments. The first beat of a sample goes to slot 0.
  - Beat with idx<NUM_A-1 and feat_last=1: slots idx+1..NUM_A-1 are cleared to 0 in the same edge, error flag is set, go to SETTLE.
  - Beat with idx=NUM_A-1: go to SETTLE. If feat_last=0, the error flag is set. No extra beats are swallowed; the next beat starts a new sample.
  - Error flag is cleared when the first beat of a sample is accepted.
- SETTLE:
  - feat_ready=0; inp is unchanged.
  - Counter loads SETTLE_CYCLES-1 on entry and decrements each cycle; at 0 go to CAPTURE.
- CAPTURE: res_class<=mlp_out, res_error<=error flag, res_valid<=1, go to RESULT.
- RESULT:
  - res_valid stays 1 and res_class/res_error are stable until res_ready.
  - res_ready samples the handshake; when res_valid&res_ready, res_valid<=0, idx<=0, go to LOAD.
  - res_ready asserted before res_valid has no effect.
- Latency:
  - Final beat accepted at edge T.
  - SETTLE occupies T+1..T+SETTLE_CYCLES.
  - Capture edge is T+SETTLE_CYCLES+1; res_valid is high after that edge.
  - Min throughput: NUM_A+SETTLE_CYCLES+2 cycles/sample with res_ready tied high.
- inp is only written in LOAD, so it never glitches during SETTLE/CAPTURE/RESULT.
- Reset mid-operation (any state): full reset values. A partially loaded sample is discarded and any pending result is dropped.
- Counter width: $clog2(SETTLE_CYCLES+1). SETTLE_CYCLES=1 means exactly one SETTLE cycle.

Optional Feature:
- Macro: MLP_SEQ_TRIPLE_SAMPLE_EN.
- Enabled:
  - CAPTURE spans 3 consecutive cycles, sampling mlp_out into s0, s1, s2.
  - res_class is the bitwise majority of s0/s1/s2.
  - res_error is also set if s0, s1 and s2 are not all equal (output unstable / transient fault indicator).
  - Latency +2 cycles; inp is still held through all three samples.
- Disabled: single-cycle capture exactly as in Behaviour.

Decomposition:
- Package mlp_seq_pkg holds:
  - state enum (LOAD, SETTLE, CAPTURE, RESULT)
  - default NUM_A/WIDTH_A/OUTWIDTH constants
  - function maj3 (bitwise majority)
- One sub-module, mlp_seq_settle_timer: load/decrement/done counter parameterised by SETTLE_CYCLES.
- The FSM and packing stay in the top module.

Test Plan:
- Beats 1,5,3,2 (last on 4th), SETTLE_CYCLES=8, mlp_out forced 2'd1 → inp=16'h2351 from the 4th accept edge; res_valid rises 9 edges after the last accept; res_class=1, res_error=0.
- Beats 7,9 with last on 2nd → inp=16'h0097, res_error=1. The following clean sample has res_error=0.
- 4 beats with feat_last=0 throughout, then 4 more beats → first result res_error=1. The second sample loads independently, so no beat is lost.
- res_ready held low 20 cycles in RESULT, feat_valid held high → feat_ready=0 and res_class/inp stable. res_ready pulse → LOAD one cycle later.
- rst_n pulsed low in SETTLE after 3 cycles → inp=0, res_valid=0 immediately (async), idx=0. The next sample completes normally.
- With MLP_SEQ_TRIPLE_SAMPLE_EN, mlp_out = 2,3,2 on the three capture cycles → res_class=2, res_error=1, latency +2 vs. disabled build.
